// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

   // Controller states of the divider
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

   // Widest operand the divider is expected to handle
   localparam int MAX_WIDTH = 64;

   // Quotient reported for a divide-by-zero: all ones in the low 'width' bits
   function automatic logic [MAX_WIDTH-1:0] dbz_quotient(input int width);
      return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 trial subtraction: partial remainder minus divisor,
// carried out one bit wider than the operands so the borrow shows the sign.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   partial,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] diff,
   output logic             non_neg
);

   logic [WIDTH:0] full_diff;

   // Trial subtract; a clear top bit means the divisor fits into the partial remainder
   always_comb begin
      full_diff = partial - {1'b0, divisor};
      diff      = full_diff[WIDTH-1:0];
      non_neg   = ~full_diff[WIDTH];
   end

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per clock.
// Signed (two's-complement) operation is compiled in only when the macro
// DIV_SEQ_SIGNED_EN is defined; otherwise is_signed is ignored and every
// operation is unsigned, with FIX kept as a one-cycle pass-through so the
// latency does not change.
module div_seq
   import div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             exception
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [MAX_WIDTH-1:0] DBZ_FULL = dbz_quotient(WIDTH);
   localparam logic [WIDTH-1:0]     DBZ_Q    = DBZ_FULL[WIDTH-1:0];

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             exception_q, exception_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q, in_ready_d;

   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   partial;
   logic [WIDTH-1:0] diff;
   logic             non_neg;

`ifdef DIV_SEQ_SIGNED_EN
   logic sign_a, sign_b;
   logic neg_quo_q, neg_quo_d;
   logic neg_rem_q, neg_rem_d;

   // Strip operand signs so the iteration always works on magnitudes
   always_comb begin
      sign_a = is_signed & dividend[WIDTH-1];
      sign_b = is_signed & divisor[WIDTH-1];
      mag_a  = sign_a ? -dividend : dividend;
      mag_b  = sign_b ? -divisor  : divisor;
   end
`else
   logic unused_is_signed;
   assign unused_is_signed = is_signed;

   // Unsigned-only build: operands are already magnitudes
   always_comb begin
      mag_a = dividend;
      mag_b = divisor;
   end
`endif

   // Next partial remainder candidate: remainder shifted left with the next dividend bit
   assign partial = {rem_q, quo_q[WIDTH-1]};

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .partial (partial),
      .divisor (dvs_q),
      .diff    (diff),
      .non_neg (non_neg)
   );

   // Next-state and datapath computation for the whole controller
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      exception_d = exception_q;
`ifdef DIV_SEQ_SIGNED_EN
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               if (divisor == '0) begin
                  state_d     = DONE;
                  quotient_d  = DBZ_Q;
                  remainder_d = dividend;
                  exception_d = 1'b1;
               end else begin
                  state_d     = RUN;
                  rem_d       = '0;
                  quo_d       = mag_a;
                  dvs_d       = mag_b;
                  cnt_d       = CW'(WIDTH - 1);
                  exception_d = 1'b0;
`ifdef DIV_SEQ_SIGNED_EN
                  neg_quo_d   = sign_a ^ sign_b;
                  neg_rem_d   = sign_a;
`endif
               end
            end
         end
         RUN: begin
            quo_d = {quo_q[WIDTH-2:0], non_neg};
            rem_d = non_neg ? diff : partial[WIDTH-1:0];
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         FIX: begin
`ifdef DIV_SEQ_SIGNED_EN
            quotient_d  = neg_quo_q ? -quo_q : quo_q;
            remainder_d = neg_rem_q ? -rem_q : rem_q;
`else
            quotient_d  = quo_q;
            remainder_d = rem_q;
`endif
            exception_d = 1'b0;
            state_d     = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               exception_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   // State, datapath and registered outputs; reset drops any operation in flight
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         exception_q <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
`ifdef DIV_SEQ_SIGNED_EN
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         exception_q <= exception_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
`ifdef DIV_SEQ_SIGNED_EN
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign exception = exception_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq (WIDTH=32): a table of directed vectors,
// hand-written stall and mid-operation reset sequences, then random operands
// checked against a plain-arithmetic reference model. Follows the
// DIV_SEQ_SIGNED_EN macro the same way the design does.
module tb_div_seq;

   localparam int W = 32;
`ifdef DIV_SEQ_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         is_signed = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         exception;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      string        name;
      logic         sgn;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         exc;
      int           lat;
   } vec_t;

   vec_t tv[10];

   div_seq #(.WIDTH(W)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .is_signed (is_signed),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .exception (exception)
   );

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
      end
   endtask

   // Reference: divide with plain integer arithmetic (truncating, remainder follows dividend)
   function automatic void refDiv(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic exc);
      longint sa, sb, lq, lr;
      if (b == '0) begin
         q = '1;
         r = a;
         exc = 1'b1;
      end else if (sgn && SIGNED_EN) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         lq = sa / sb;
         lr = sa % sb;
         q = lq[W-1:0];
         r = lr[W-1:0];
         exc = 1'b0;
      end else begin
         q = a / b;
         r = a % b;
         exc = 1'b0;
      end
   endfunction

   // One full transaction: transfer, wait for result, optional stall with junk inputs, release
   task automatic applyStimulus(input string name, input logic sgn, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er,
                                input logic eexc, input int elat, input int hold);
      int guard;
      int lat;
      lat = -1;
      guard = 0;
      @(negedge clock);
      while (!in_ready && guard < 200) begin
         @(negedge clock);
         guard++;
      end
      is_signed = sgn;
      dividend = a;
      divisor = b;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      dividend = $urandom;
      divisor = $urandom;
      is_signed = 1'($urandom_range(0, 1));
      for (int n = 0; n < 200 && lat < 0; n++) begin
         if (n > 0) begin
            @(posedge clock);
            #1;
         end
         if (out_valid) lat = n + 1;
      end
      if (lat < 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL %s timeout: out_valid never rose, want it after %0d cycles", name, elat);
         return;
      end
      checkOutput({name, " latency"}, 64'(lat), 64'(elat));
      checkOutput({name, " quotient"}, 64'(quotient), 64'(eq));
      checkOutput({name, " remainder"}, 64'(remainder), 64'(er));
      checkOutput({name, " exception"}, 64'(exception), 64'(eexc));
      for (int h = 0; h < hold; h++) begin
         @(negedge clock);
         checkOutput({name, " stall in_ready"}, 64'(in_ready), 64'(0));
         checkOutput({name, " stall out_valid"}, 64'(out_valid), 64'(1));
         checkOutput({name, " stall quotient"}, 64'(quotient), 64'(eq));
         checkOutput({name, " stall remainder"}, 64'(remainder), 64'(er));
         in_valid = (h % 2 == 0);
         dividend = $urandom;
         divisor = (h % 4 == 1) ? '0 : W'($urandom);
      end
      @(negedge clock);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
      checkOutput({name, " release out_valid"}, 64'(out_valid), 64'(0));
      checkOutput({name, " release in_ready"}, 64'(in_ready), 64'(1));
   endtask

   initial begin
      logic [W-1:0] rq, rr, ra, rb;
      logic         rexc, rsgn;
      int           guard, seen, sel;

      tv[0] = '{"u 100/7",        1'b0, 32'd100,        32'd7,          32'd14,         32'd2,   1'b0, W + 2};
      tv[1] = '{"s -7/2",         1'b1, 32'hFFFF_FFF9,  32'd2,
                SIGNED_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC,
                SIGNED_EN ? 32'hFFFF_FFFF : 32'h0000_0001, 1'b0, W + 2};
      tv[2] = '{"u 5/0",          1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,   1'b1, 1};
      tv[3] = '{"s min/-1",       1'b1, 32'h8000_0000,  32'hFFFF_FFFF,
                SIGNED_EN ? 32'h8000_0000 : 32'h0000_0000,
                SIGNED_EN ? 32'h0000_0000 : 32'h8000_0000, 1'b0, W + 2};
      tv[4] = '{"u max/1",        1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,   1'b0, W + 2};
      tv[5] = '{"u 3/10",         1'b0, 32'd3,          32'd10,         32'd0,          32'd3,   1'b0, W + 2};
      tv[6] = '{"s 7/-2",         1'b1, 32'd7,          32'hFFFF_FFFE,
                SIGNED_EN ? 32'hFFFF_FFFD : 32'h0000_0000,
                SIGNED_EN ? 32'h0000_0001 : 32'h0000_0007, 1'b0, W + 2};
      tv[7] = '{"s -10/-3",       1'b1, 32'hFFFF_FFF6,  32'hFFFF_FFFD,
                SIGNED_EN ? 32'h0000_0003 : 32'h0000_0000,
                SIGNED_EN ? 32'hFFFF_FFFF : 32'hFFFF_FFF6, 1'b0, W + 2};
      tv[8] = '{"s 0/0",          1'b1, 32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,   1'b1, 1};
      tv[9] = '{"u x/x",          1'b0, 32'h1234_5678,  32'h1234_5678,  32'd1,          32'd0,   1'b0, W + 2};

      // Reset state while reset_n is held low
      #12;
      checkOutput("reset in_ready", 64'(in_ready), 64'(1));
      checkOutput("reset out_valid", 64'(out_valid), 64'(0));
      checkOutput("reset quotient", 64'(quotient), 64'(0));
      checkOutput("reset remainder", 64'(remainder), 64'(0));
      checkOutput("reset exception", 64'(exception), 64'(0));
      @(negedge clock);
      reset_n = 1'b1;

      foreach (tv[i]) begin
         applyStimulus(tv[i].name, tv[i].sgn, tv[i].a, tv[i].b, tv[i].q, tv[i].r, tv[i].exc, tv[i].lat, 0);
      end

      // Consumer stalls for 10 cycles while junk operands are offered
      applyStimulus("stall 1000/3", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, W + 2, 10);

      // Reset in the middle of RUN: outputs clear at once, the operation never completes
      @(negedge clock);
      guard = 0;
      while (!in_ready && guard < 200) begin
         @(negedge clock);
         guard++;
      end
      is_signed = 1'b0;
      dividend = 32'hDEAD_BEEF;
      divisor = 32'd7;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("midrun reset quotient", 64'(quotient), 64'(0));
      checkOutput("midrun reset remainder", 64'(remainder), 64'(0));
      checkOutput("midrun reset out_valid", 64'(out_valid), 64'(0));
      checkOutput("midrun reset in_ready", 64'(in_ready), 64'(1));
      checkOutput("midrun reset exception", 64'(exception), 64'(0));
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      seen = 0;
      repeat (W + 10) begin
         @(posedge clock);
         #1;
         if (out_valid) seen++;
      end
      checkOutput("no out_valid after reset", 64'(seen), 64'(0));
      applyStimulus("after reset 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, W + 2, 0);

      // Random operands against the reference model
      for (int k = 0; k < 40; k++) begin
         rsgn = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 9);
         ra = (sel == 9) ? 32'h8000_0000 : W'($urandom);
         case (sel)
            0:       rb = '0;
            1:       rb = 32'd1;
            2:       rb = '1;
            3:       rb = W'($urandom_range(2, 15));
            default: rb = W'($urandom >> $urandom_range(0, 28));
         endcase
         refDiv(rsgn, ra, rb, rq, rr, rexc);
         applyStimulus($sformatf("rand%0d", k), rsgn, ra, rb, rq, rr, rexc, (rb == '0) ? 1 : W + 2, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
